round_window_multi: RTL and testbench

Parametrised successor to the single-pair round block in the sparse-polynomial multiplier datapath. It keeps a circular history of incoming dense-polynomial words. For every accepted word it emits LANES independent (left, right) adjacent-word pairs, each taken at a programmable distance behind the newest word. Outside the valid polynomial index range it emits zeros. The block sits between the dense-word streamer and the per-lane shift/XOR accumulators, and adds output backpressure and an add-only mode.

---
 rtl/round_window_multi.sv | 143 ++++++++++++++
 tb/tb_round_window_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_window_multi.sv
// Circular history of dense-polynomial words. Each emitting word produces LANES
// (left, right) adjacent-word pairs taken at a per-lane distance behind the newest word.
module round_window_multi #(
    parameter int WORD_WIDTH        = 32,
    parameter int DEPTH             = 32,
    parameter int PTR_W             = 5,
    parameter int LANES             = 2,
    parameter int OFS_W             = 6,
    parameter int CNT_W             = 10,
    parameter int NORMAL_WORD_COUNT = 553
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_WIDTH-1:0]       in_word,
    input  logic                        add_only,
    input  logic [LANES*OFS_W-1:0]      lane_offset,
    input  logic [LANES-1:0]            lane_latency,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*WORD_WIDTH-1:0] out_left,
    output logic [LANES*WORD_WIDTH-1:0] out_right,
    output logic                        add_done,
    output logic                        cfg_err
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    localparam logic signed [CNT_W:0] J_ONE = (CNT_W+1)'(1);
    localparam logic signed [CNT_W:0] J_MAX = (CNT_W+1)'(NORMAL_WORD_COUNT);

    state_t                        state_reg, state_next;
    logic [PTR_W-1:0]              wp_reg;
    logic [CNT_W-1:0]              n_reg;
    logic                          out_valid_reg;
    logic                          add_done_reg;
    logic                          cfg_err_reg;
    logic [LANES*WORD_WIDTH-1:0]   left_reg, right_reg;
    logic [LANES*WORD_WIDTH-1:0]   left_next, right_next;
    logic [LANES-1:0]              lane_err;
    logic                          accept;

    logic [WORD_WIDTH-1:0]         mem [DEPTH];

    // A word arriving together with frame_clear is discarded entirely.
    assign accept = in_valid && in_ready && !frame_clear;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp_reg] <= in_word;
        end
    end

    // wp_reg and n_reg are already post-increment when READ evaluates the lanes,
    // so mem[wp_reg-1] is the newest word with index n_reg.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [OFS_W:0]        e;
        logic [PTR_W-1:0]      addr_l, addr_r;
        logic signed [CNT_W:0] jl, jr;
        logic                  ok_l, ok_r;

        assign e        = {1'b0, lane_offset[gi*OFS_W +: OFS_W]} + {{OFS_W{1'b0}}, lane_latency[gi]};
        assign lane_err[gi] = (32'(e) + 32'd1) >= 32'(DEPTH);
        assign addr_l   = wp_reg - PTR_W'(1) - PTR_W'(e);
        assign addr_r   = addr_l - PTR_W'(1);
        assign jl       = $signed({1'b0, n_reg}) - $signed((CNT_W+1)'(e));
        assign jr       = jl - J_ONE;
        assign ok_l     = !lane_err[gi] && (jl >= J_ONE) && (jl <= J_MAX);
        assign ok_r     = !lane_err[gi] && (jr >= J_ONE) && (jr <= J_MAX);

        assign left_next[gi*WORD_WIDTH +: WORD_WIDTH]  = ok_l ? mem[addr_l] : '0;
        assign right_next[gi*WORD_WIDTH +: WORD_WIDTH] = ok_r ? mem[addr_r] : '0;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (accept && !add_only) begin
                    state_next = READ;
                end
            end
            READ: state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wp_reg        <= '0;
            n_reg         <= '0;
            out_valid_reg <= 1'b0;
            add_done_reg  <= 1'b0;
            cfg_err_reg   <= 1'b0;
            left_reg      <= '0;
            right_reg     <= '0;
        end else begin
            cfg_err_reg <= |lane_err;
            if (frame_clear) begin
                state_reg     <= IDLE;
                wp_reg        <= '0;
                n_reg         <= '0;
                out_valid_reg <= 1'b0;
                add_done_reg  <= 1'b0;
                left_reg      <= '0;
                right_reg     <= '0;
            end else begin
                state_reg    <= state_next;
                add_done_reg <= accept && add_only;
                if (accept) begin
                    wp_reg <= wp_reg + PTR_W'(1);
                    if (!(&n_reg)) begin
                        n_reg <= n_reg + CNT_W'(1);
                    end
                end
                if (state_reg == READ) begin
                    out_valid_reg <= 1'b1;
                    left_reg      <= left_next;
                    right_reg     <= right_next;
                end else if (state_reg == HOLD && out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_left  = left_reg;
    assign out_right = right_reg;
    assign add_done  = add_done_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_round_window_multi.sv
// Directed bench for round_window_multi: three instances (default, DEPTH=8, NWC=6) share one stimulus stream.
module tb_round_window_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;
    logic        add_only = 1'b0;
    logic [5:0]  d0 = '0, d1 = '0;
    logic        l0 = 1'b0, l1 = 1'b0;
    logic        out_ready = 1'b0;

    logic [11:0] lane_offset;
    logic [1:0]  lane_latency;
    assign lane_offset  = {d1, d0};
    assign lane_latency = {l1, l0};

    // index 0 = default, 1 = DEPTH 8, 2 = NORMAL_WORD_COUNT 6
    logic        ir [3];
    logic        ov [3];
    logic [63:0] ol [3];
    logic [63:0] orr [3];
    logic        ad [3];
    logic        ce [3];

    logic [63:0] cap_l [3];
    logic [63:0] cap_r [3];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    round_window_multi u_big (
        .clk(clk), .rst_n(rst_n), .frame_clear(frame_clear),
        .in_valid(in_valid), .in_ready(ir[0]), .in_word(in_word), .add_only(add_only),
        .lane_offset(lane_offset), .lane_latency(lane_latency),
        .out_valid(ov[0]), .out_ready(out_ready), .out_left(ol[0]), .out_right(orr[0]),
        .add_done(ad[0]), .cfg_err(ce[0])
    );

    round_window_multi #(.DEPTH(8), .PTR_W(3)) u_wrap (
        .clk(clk), .rst_n(rst_n), .frame_clear(frame_clear),
        .in_valid(in_valid), .in_ready(ir[1]), .in_word(in_word), .add_only(add_only),
        .lane_offset(lane_offset), .lane_latency(lane_latency),
        .out_valid(ov[1]), .out_ready(out_ready), .out_left(ol[1]), .out_right(orr[1]),
        .add_done(ad[1]), .cfg_err(ce[1])
    );

    round_window_multi #(.NORMAL_WORD_COUNT(6)) u_tail (
        .clk(clk), .rst_n(rst_n), .frame_clear(frame_clear),
        .in_valid(in_valid), .in_ready(ir[2]), .in_word(in_word), .add_only(add_only),
        .lane_offset(lane_offset), .lane_latency(lane_latency),
        .out_valid(ov[2]), .out_ready(out_ready), .out_left(ol[2]), .out_right(orr[2]),
        .add_done(ad[2]), .cfg_err(ce[2])
    );

    typedef struct {
        int          sel;
        bit          clr;
        logic [5:0]  d0, d1;
        logic        l0, l1;
        logic [31:0] w;
        logic [31:0] el0, er0, el1, er1;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(int sel, bit clr, logic [5:0] a0, logic b0, logic [5:0] a1, logic b1,
                                logic [31:0] w, logic [31:0] el0, logic [31:0] er0,
                                logic [31:0] el1, logic [31:0] er1);
        vec_t v;
        v.sel = sel; v.clr = clr; v.d0 = a0; v.l0 = b0; v.d1 = a1; v.l1 = b1;
        v.w = w; v.el0 = el0; v.er0 = er0; v.el1 = el1; v.er1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk); frame_clear = 1'b1;
        @(negedge clk); frame_clear = 1'b0;
    endtask

    // Offer one emitting word, wait (bounded) for out_valid, capture, then consume.
    task automatic send_word(input logic [31:0] w);
        int t;
        @(negedge clk); in_valid = 1'b1; in_word = w; add_only = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        t = 0;
        while (!ov[0] && t < 8) begin
            @(negedge clk); t++;
        end
        chk("out_valid_arrives", 64'(ov[0]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cap_l[k] = ol[k];
            cap_r[k] = orr[k];
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    // Offer a word and stop in HOLD with out_ready low.
    task automatic send_to_hold(input logic [31:0] w);
        @(negedge clk); in_valid = 1'b1; in_word = w; add_only = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("hold_out_valid", 64'(ov[0]), 64'd1);
    endtask

    initial begin
        logic [63:0] snap_l, snap_r;
        logic [31:0] base;

        // d0 d1 l0 l1 word -> lane0 (L,R), lane1 (L,R)
        vt[0]  = mk(0, 1, 0, 0, 3, 0, 1, 1, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 3, 0, 2, 2, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 3, 0, 3, 3, 2, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 3, 0, 4, 4, 3, 1, 0);
        vt[4]  = mk(0, 0, 0, 0, 3, 0, 5, 5, 4, 2, 1);
        vt[5]  = mk(0, 0, 0, 0, 3, 0, 6, 6, 5, 3, 2);
        vt[6]  = mk(0, 0, 0, 0, 3, 0, 7, 7, 6, 4, 3);
        vt[7]  = mk(0, 0, 0, 0, 3, 0, 8, 8, 7, 5, 4);
        vt[8]  = mk(2, 1, 0, 1, 3, 0, 1, 0, 0, 0, 0);
        vt[9]  = mk(2, 0, 0, 1, 3, 0, 2, 1, 0, 0, 0);
        vt[10] = mk(2, 0, 0, 1, 3, 0, 3, 2, 1, 0, 0);
        vt[11] = mk(2, 0, 0, 1, 3, 0, 4, 3, 2, 1, 0);
        vt[12] = mk(2, 0, 0, 1, 3, 0, 5, 4, 3, 2, 1);
        vt[13] = mk(2, 0, 0, 1, 3, 0, 6, 5, 4, 3, 2);
        vt[14] = mk(2, 0, 0, 1, 3, 0, 7, 6, 5, 4, 3);
        vt[15] = mk(2, 0, 0, 1, 3, 0, 8, 0, 6, 5, 4);

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(ir[0]), 64'd1);
        chk("reset_out_valid", 64'(ov[0]), 64'd0);
        chk("reset_out_left", ol[0], 64'd0);
        chk("reset_out_right", orr[0], 64'd0);
        chk("reset_add_done", 64'(ad[0]), 64'd0);
        chk("reset_cfg_err", 64'(ce[0]), 64'd0);
        rst_n = 1'b1;

        // Basic sequence and latency/tail vectors
        for (int i = 0; i < 16; i++) begin
            if (vt[i].clr) do_clear();
            d0 = vt[i].d0; l0 = vt[i].l0; d1 = vt[i].d1; l1 = vt[i].l1;
            send_word(vt[i].w);
            chk($sformatf("vec%0d_l0", i), 64'(cap_l[vt[i].sel][31:0]),  64'(vt[i].el0));
            chk($sformatf("vec%0d_r0", i), 64'(cap_r[vt[i].sel][31:0]),  64'(vt[i].er0));
            chk($sformatf("vec%0d_l1", i), 64'(cap_l[vt[i].sel][63:32]), 64'(vt[i].el1));
            chk($sformatf("vec%0d_r1", i), 64'(cap_r[vt[i].sel][63:32]), 64'(vt[i].er1));
            $display("vec %0d word %0d: L=%h R=%h", i, vt[i].w, cap_l[vt[i].sel], cap_r[vt[i].sel]);
        end

        // Backpressure: word 4 held for 10 cycles
        do_clear();
        d0 = 0; l0 = 0; d1 = 3; l1 = 0;
        for (int w = 1; w <= 3; w++) send_word(32'(w));
        send_to_hold(32'd4);
        snap_l = ol[0]; snap_r = orr[0];
        chk("bp_left", snap_l, {32'd1, 32'd4});
        chk("bp_right", snap_r, {32'd0, 32'd3});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
            chk("bp_data", {ol[0][31:0], orr[0][31:0]}, {snap_l[31:0], snap_r[31:0]});
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("bp_release_valid", 64'(ov[0]), 64'd0);
        chk("bp_release_ready", 64'(ir[0]), 64'd1);
        $display("backpressure word 4: L=%h R=%h", snap_l, snap_r);

        // Three back-to-back add_only words
        do_clear();
        @(negedge clk); in_valid = 1'b1; add_only = 1'b1; in_word = 32'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("add_done_%0d", k), 64'(ad[0]), 64'd1);
            chk($sformatf("add_no_valid_%0d", k), 64'(ov[0]), 64'd0);
            in_word = 32'(k + 1);
            $display("add_only word %0d: add_done=%0d", k, ad[0]);
        end
        in_valid = 1'b0; add_only = 1'b0;
        @(negedge clk);
        chk("add_done_low", 64'(ad[0]), 64'd0);
        send_word(32'd4);
        chk("after_add_left", cap_l[0], {32'd1, 32'd4});
        chk("after_add_right", cap_r[0], {32'd0, 32'd3});

        // Wrap-around on DEPTH=8 with d1=5
        do_clear();
        d0 = 0; d1 = 5;
        base = 32'hA000;
        for (int n = 1; n <= 20; n++) begin
            send_word(base + 32'(n));
            chk($sformatf("wrap%0d_left", n), cap_l[1],
                {(n > 5) ? base + 32'(n - 5) : 32'd0, base + 32'(n)});
            chk($sformatf("wrap%0d_right", n), cap_r[1],
                {(n > 6) ? base + 32'(n - 6) : 32'd0, (n > 1) ? base + 32'(n - 1) : 32'd0});
            $display("wrap word %0d: L=%h R=%h", n, cap_l[1], cap_r[1]);
        end
        d1 = 7;
        repeat (2) @(negedge clk);
        chk("cfg_err_small", 64'(ce[1]), 64'd1);
        chk("cfg_err_big", 64'(ce[0]), 64'd0);
        send_word(32'hB000);
        chk("cfg_err_lane1_zero", {cap_l[1][63:32], cap_r[1][63:32]}, 64'd0);
        chk("cfg_err_lane0_ok", {cap_l[1][31:0], cap_r[1][31:0]}, {32'hB000, base + 32'd20});
        d1 = 5;
        repeat (2) @(negedge clk);
        chk("cfg_err_clears", 64'(ce[1]), 64'd0);

        // frame_clear mid-stream
        do_clear();
        d1 = 3;
        for (int w = 1; w <= 10; w++) send_word(32'(w));
        do_clear();
        send_word(32'h0000AAAA);
        chk("fc_left", cap_l[0], {32'd0, 32'h0000AAAA});
        chk("fc_right", cap_r[0], 64'd0);
        $display("frame_clear word A: L=%h R=%h", cap_l[0], cap_r[0]);

        // frame_clear in HOLD overrides a simultaneous out_ready
        send_to_hold(32'h55);
        frame_clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0; out_ready = 1'b0;
        chk("fc_hold_valid", 64'(ov[0]), 64'd0);
        chk("fc_hold_left", ol[0], 64'd0);
        chk("fc_hold_ready", 64'(ir[0]), 64'd1);

        // Asynchronous reset in HOLD
        send_to_hold(32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ov[0]), 64'd0);
        chk("arst_left", ol[0], 64'd0);
        chk("arst_right", orr[0], 64'd0);
        chk("arst_in_ready", 64'(ir[0]), 64'd1);
        chk("arst_add_done", 64'(ad[0]), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", 64'(ir[0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
